// File: rtl/key_event_pkg.sv
// key_event_pkg: shared state encoding, default timing constants and key indices.
// Used by key_event_chan, key_event_gen and the bench; declares no ports.
package key_event_pkg;
  typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED, HELD} key_state_t;
  localparam int HOLD_TICKS_DEF = 100;
  localparam int REPEAT_TICKS_DEF = 25;
  localparam int CNT_W_DEF = 7;
  localparam int K_MODE = 0;
  localparam int K_INCX = 1;
  localparam int K_INCY = 2;
  localparam int K_ANS = 3;
  localparam int K_AUTO = 4;
endpackage

// File: rtl/key_event_gen_if.sv
// key_event_gen_if: key levels in, event pulses and key-down levels out.
// master drives key_lvl/repeat_en and observes the events; slave is key_event_gen.
//   key_lvl, repeat_en                                   master -> slave
//   press_pulse, release_pulse, hold_pulse, repeat_pulse  slave -> master
//   key_down, any_down                                    slave -> master
interface key_event_gen_if #(parameter int NUM_KEYS = 5);
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] repeat_en;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] hold_pulse;
  logic [NUM_KEYS-1:0] repeat_pulse;
  logic [NUM_KEYS-1:0] key_down;
  logic any_down;
  modport master(output key_lvl, repeat_en,
                 input press_pulse, release_pulse, hold_pulse, repeat_pulse, key_down, any_down);
  modport slave(input key_lvl, repeat_en,
                output press_pulse, release_pulse, hold_pulse, repeat_pulse, key_down, any_down);
endinterface

// File: rtl/key_event_chan.sv
// key_event_chan: one key's press/release/hold/repeat FSM with its tick counter.
//   clk_100hz, rst_ (async, active-low)
//   key_lvl, repeat_en in; press/release/hold/repeat pulses and key_down out (all registered)
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk_100hz,
  input  logic rst_,
  input  logic key_lvl,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic key_down
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
  key_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic hold_hit, rep_hit, pressing, releasing;
  // thresholds only count while the key is still high, so a release on that edge wins
  assign hold_hit = state == PRESSED && key_lvl && cnt == HOLD_LAST;
  assign rep_hit = state == HELD && key_lvl && repeat_en && cnt == REP_LAST;
  assign pressing = state == IDLE && key_lvl;
  assign releasing = (state == PRESSED || state == HELD) && !key_lvl;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      WAIT_REL: state_n = key_lvl ? WAIT_REL : IDLE;
      IDLE: begin
        state_n = key_lvl ? PRESSED : IDLE;
        cnt_n = '0;
      end
      PRESSED: begin
        state_n = !key_lvl ? IDLE : hold_hit ? HELD : PRESSED;
        cnt_n = (!key_lvl || hold_hit) ? '0 : cnt + 1'b1;
      end
      HELD: begin
        state_n = key_lvl ? HELD : IDLE;
        // repeat_en low freezes the count so re-enabling resumes mid-interval
        cnt_n = (!key_lvl || rep_hit) ? '0 : repeat_en ? cnt + 1'b1 : cnt;
      end
    endcase
  end
  always_ff @(posedge clk_100hz or negedge rst_)
    if (!rst_) begin
      state <= WAIT_REL;
      cnt <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      key_down <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      press_pulse <= pressing;
      release_pulse <= releasing;
      hold_pulse <= hold_hit;
      repeat_pulse <= rep_hit;
      key_down <= state_n == PRESSED || state_n == HELD;
    end
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: NUM_KEYS independent key event channels plus an any-key-down flag.
//   clk_100hz, rst_ (async, active-low)
//   bus: key_event_gen_if.slave carrying key levels in and event pulses/levels out
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS = 5,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk_100hz,
  input logic rst_,
  key_event_gen_if.slave bus
);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_event_chan #(
      .HOLD_TICKS(HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_100hz(clk_100hz),
      .rst_(rst_),
      .key_lvl(bus.key_lvl[k]),
      .repeat_en(bus.repeat_en[k]),
      .press_pulse(bus.press_pulse[k]),
      .release_pulse(bus.release_pulse[k]),
      .hold_pulse(bus.hold_pulse[k]),
      .repeat_pulse(bus.repeat_pulse[k]),
      .key_down(bus.key_down[k])
    );
  end
  // OR of registered levels only, so still no input-to-output path
  assign bus.any_down = |bus.key_down;
endmodule
